// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared decode types, opcodes and immediate-mode classification
package cpu_pkg;

    typedef enum logic [2:0] {
        IMM_NONE   = 3'd0,
        IMM_SIGN   = 3'd1,
        IMM_ZERO   = 3'd2,
        IMM_UPPER  = 3'd3,
        IMM_BRANCH = 3'd4
    } imm_mode_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    // One buffered decode result: the immediate is formed before storage.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        imm_mode_t   mode;
    } imm_entry_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LWL   = 6'h22;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic imm_mode_t decode_imm_mode(input logic [5:0] opcode);
        imm_mode_t mode;
        mode = IMM_NONE;
        case (opcode)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW:                  mode = IMM_SIGN;
            OP_ANDI, OP_ORI, OP_XORI:             mode = IMM_ZERO;
            OP_LUI:                               mode = IMM_UPPER;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:     mode = IMM_BRANCH;
            default:                              mode = IMM_NONE;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/sign_extension_unit_16_32.sv
// rtl/sign_extension_unit_16_32.sv - 16-to-32-bit sign extension
// Ports: imm_in [15:0] raw immediate field; imm_out [31:0] sign-extended value.
module sign_extension_unit_16_32 (
    input  logic [15:0] imm_in,
    output logic [31:0] imm_out
);

    assign imm_out = {{16{imm_in[15]}}, imm_in};

endmodule

// File: rtl/immediate_extend_stage.sv
// rtl/immediate_extend_stage.sv - decode-stage immediate generator with two-entry skid buffer
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   flush                 discard all buffered entries, handshake that cycle ignored
//   in_valid/in_ready     fetch handshake (in_ready registered, occupancy only)
//   in_instr [31:0]       instruction word from fetch
//   out_valid/out_ready   execute handshake for the head entry
//   out_imm [31:0]        formed immediate of the head entry
//   out_mode [2:0]        imm_mode_t of the head entry
//   out_instr [31:0]      instruction word of the head entry
module immediate_extend_stage
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_imm,
    output logic [2:0]  out_mode,
    output logic [31:0] out_instr
);

    if (DEPTH != 2) begin : g_bad_depth
        $error("immediate_extend_stage: DEPTH must be 2");
    end

    // ---------------------------------------------------------------
    // Immediate formation on the incoming instruction
    // ---------------------------------------------------------------
    logic [31:0] sext_imm;
    imm_mode_t   new_mode;
    logic [31:0] new_imm;
    imm_entry_t  new_entry;

    sign_extension_unit_16_32 u_sext (
        .imm_in  (in_instr[15:0]),
        .imm_out (sext_imm)
    );

    assign new_mode = decode_imm_mode(in_instr[31:26]);

    always_comb begin
        new_imm = 32'h0;
        case (new_mode)
            IMM_SIGN:   new_imm = sext_imm;
            IMM_ZERO:   new_imm = {16'h0, in_instr[15:0]};
            IMM_UPPER:  new_imm = {in_instr[15:0], 16'h0};
            // Word offset: shift the sign-extended value, top two bits drop out.
            IMM_BRANCH: new_imm = {sext_imm[29:0], 2'b00};
            default:    new_imm = 32'h0;
        endcase
    end

    assign new_entry = '{instr: in_instr, imm: new_imm, mode: new_mode};

    // ---------------------------------------------------------------
    // Occupancy FSM
    // ---------------------------------------------------------------
    occ_state_t state, state_next;
    logic       push, pop;
    logic       load_head_new, load_head_skid, load_skid;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (push) begin
                        state_next    = OCC_ONE;
                        load_head_new = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        load_head_new = 1'b1;
                    end else if (push) begin
                        state_next = OCC_FULL;
                        load_skid  = 1'b1;
                    end else if (pop) begin
                        state_next = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here, so no push can occur.
                    if (pop) begin
                        state_next     = OCC_ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_next = OCC_EMPTY;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Storage and registered handshake outputs
    // ---------------------------------------------------------------
    imm_entry_t head, skid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head      <= '{instr: 32'h0, imm: 32'h0, mode: IMM_NONE};
            skid      <= '{instr: 32'h0, imm: 32'h0, mode: IMM_NONE};
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            // Flags track the next state so both stay pure flop outputs.
            out_valid <= (state_next != OCC_EMPTY);
            in_ready  <= (state_next != OCC_FULL);
            if (load_head_new) begin
                head <= new_entry;
            end else if (load_head_skid) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= new_entry;
            end
        end
    end

    assign out_imm   = head.imm;
    assign out_mode  = head.mode;
    assign out_instr = head.instr;

endmodule

// File: tb/tb_immediate_extend_stage.sv
// tb/tb_immediate_extend_stage.sv - scoreboard bench for immediate_extend_stage
module tb_immediate_extend_stage;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_mode;
    logic [31:0] out_instr;

    int total = 0;
    int bad   = 0;

    logic [66:0] sb[$];   // {instr, imm, mode}

    immediate_extend_stage #(.DEPTH(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_mode  (out_mode),
        .out_instr (out_instr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one instruction; the expectation is queued at the negedge that
    // sees the accept, and the task returns just after the accepting edge.
    task automatic push_one(input logic [31:0] instr, input logic [31:0] imm,
                            input logic [2:0] mode);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_instr = instr;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clock);
            if (in_ready) begin
                sb.push_back({instr, imm, mode});
                done = 1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL push_timeout: in_ready stuck 0 for instr %08h", instr);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: a pop happens at the next edge whenever out_valid & out_ready.
    always @(negedge clock) begin
        if (!reset && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got instr %08h expected none", out_instr);
            end else begin
                logic [66:0] e;
                e = sb.pop_front();
                chk("out_instr", out_instr, e[66:35]);
                chk("out_imm", out_imm, e[34:3]);
                chk("out_mode", {29'h0, out_mode}, {29'h0, e[2:0]});
            end
        end
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_out_imm", out_imm, 32'h0);
        chk("rst_out_mode", {29'h0, out_mode}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Single addi, one-cycle latency.
        out_ready = 1'b1;
        push_one(32'h2022FFFE, 32'hFFFFFFFE, 3'd1);
        chk("lat_out_valid", {31'h0, out_valid}, 32'd1);
        tick();

        // Back-to-back ori, lui, beq.
        push_one(32'h34228001, 32'h00008001, 3'd2);
        push_one(32'h3C011234, 32'h12340000, 3'd3);
        push_one(32'h1022FFFF, 32'hFFFFFFFC, 3'd4);
        repeat (3) tick();
        chk("drain1_empty", sb.size(), 32'd0);

        // Fill to FULL with out_ready low, third instruction held by fetch.
        out_ready = 1'b0;
        push_one(32'h8C228000, 32'hFFFF8000, 3'd1);   // lw
        push_one(32'hAC227FFF, 32'h00007FFF, 3'd1);   // sw
        chk("full_in_ready", {31'h0, in_ready}, 32'd0);
        fork
            push_one(32'h3822FFFF, 32'h0000FFFF, 3'd2); // xori
            begin
                repeat (3) tick();
                chk("held_in_ready", {31'h0, in_ready}, 32'd0);
                chk("held_head", out_instr, 32'h8C228000);
                chk("held_valid", {31'h0, out_valid}, 32'd1);
                out_ready = 1'b1;
                tick();
                chk("after_pop_in_ready", {31'h0, in_ready}, 32'd1);
            end
        join
        repeat (4) tick();
        chk("drain2_empty", sb.size(), 32'd0);

        // ONE state with simultaneous push and pop.
        out_ready = 1'b0;
        push_one(32'h28220001, 32'h00000001, 3'd1);   // slti
        out_ready = 1'b1;
        push_one(32'h14220002, 32'h00000008, 3'd4);   // bne
        chk("pp_valid", {31'h0, out_valid}, 32'd1);
        chk("pp_in_ready", {31'h0, in_ready}, 32'd1);
        chk("pp_head", out_instr, 32'h14220002);
        repeat (3) tick();
        chk("drain3_empty", sb.size(), 32'd0);

        // Flush in FULL with in_valid and out_ready both high.
        out_ready = 1'b0;
        push_one(32'h18200010, 32'h00000040, 3'd4);   // blez
        push_one(32'h1C208000, 32'hFFFE0000, 3'd4);   // bgtz
        in_valid  = 1'b1;
        in_instr  = 32'h24220005;                     // addiu, must be dropped
        out_ready = 1'b1;
        flush     = 1'b1;
        sb.delete();
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {31'h0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'h0, in_ready}, 32'd1);
        repeat (2) tick();
        chk("flush_still_empty", {31'h0, out_valid}, 32'd0);

        // Asynchronous reset mid-cycle while FULL.
        out_ready = 1'b0;
        push_one(32'h3C01ABCD, 32'hABCD0000, 3'd3);
        push_one(32'h3021F0F0, 32'h0000F0F0, 3'd2);
        #3;
        in_valid = 1'b1;
        in_instr = 32'h2021000F;
        reset    = 1'b1;
        sb.delete();
        #1;
        chk("arst_valid", {31'h0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("arst_imm", out_imm, 32'h0);
        chk("arst_mode", {29'h0, out_mode}, 32'd0);
        chk("arst_instr", out_instr, 32'h0);
        in_valid = 1'b0;
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("arst_no_inflight", {31'h0, out_valid}, 32'd0);
        push_one(32'h012A4020, 32'h00000000, 3'd0);   // add (R-type)
        push_one(32'h08000010, 32'h00000000, 3'd0);   // j
        repeat (3) tick();
        chk("final_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
